freq_meter: RTL

Gated frequency meter that counts rising edges of an asynchronous input over a fixed window of `clk` cycles. At the end of each window it publishes the count as packed BCD digits for the 7-segment decoder path. It is the measuring counterpart of the team's clock divider: that block produces a slow signal from `clk`, and this block measures such a signal against `clk`. It sits between a board input (or a divider output looped back) and the BCD-to-7-segment display chain.

---
 rtl/freq_meter_pkg.sv | 16 +
 rtl/freq_meter_bcd_digit_counter.sv | 24 ++
 rtl/freq_meter.sv | 90 +++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared BCD types and the single-digit decade step used by the frequency meter
// and the 7-segment decoder path.
package freq_meter_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // Next value of one decade digit; hold freezes it when the whole counter is saturated.
    function automatic bcd_digit_t bcd_next(bcd_digit_t q, logic inc, logic hold);
        if (!inc || hold) begin
            return q;
        end
        return (q == BCD_MAX) ? bcd_digit_t'(0) : q + bcd_digit_t'(1);
    endfunction
endpackage

// File: rtl/freq_meter_bcd_digit_counter.sv
// One decade digit of the working counter; carry ripples combinationally to the next digit.
module bcd_digit_counter
    import freq_meter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    input  logic       hold,
    output bcd_digit_t q,
    output logic       carry
);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            q <= '0;
        end else begin
            q <= bcd_next(q, inc, hold);
        end
    end

    assign carry = inc & (q == BCD_MAX);

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a free-running
// window of GATE_CYCLES clk cycles and latches the BCD result at each window end.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 25000000,
    parameter int DIGITS      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sig_in,
    output logic [4*DIGITS-1:0]   freq_bcd,
    output logic                  overflow,
    output logic                  valid
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    logic                s1, s2, s3;
    logic                sig_edge;
    logic [GW-1:0]       gcnt;
    logic                win_end;
    bcd_digit_t          work [DIGITS];
    logic [DIGITS:0]     inc_chain;
    logic                sat;
    logic                ovf_work;
    logic [4*DIGITS-1:0] work_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sig_edge = s2 & ~s3;

    always_ff @(posedge clk) begin
        if (!reset || win_end) begin
            gcnt <= '0;
        end else begin
            gcnt <= gcnt + GW'(1);
        end
    end

    assign win_end = (gcnt == GATE_LAST);

    // The carry out of the top digit is exactly "all nines and an edge": the saturation condition.
    assign inc_chain[0] = sig_edge;
    assign sat          = inc_chain[DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_counter u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (win_end),
            .inc   (inc_chain[i]),
            .hold  (sat),
            .q     (work[i]),
            .carry (inc_chain[i+1])
        );
        assign work_next[i*BCD_W +: BCD_W] = bcd_next(work[i], inc_chain[i], sat);
    end

    // The latch takes the post-increment value so an edge in the window-end cycle is kept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            freq_bcd <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
            ovf_work <= 1'b0;
        end else begin
            valid <= win_end;
            if (win_end) begin
                freq_bcd <= work_next;
                overflow <= ovf_work | sat;
                ovf_work <= 1'b0;
            end else if (sat) begin
                ovf_work <= 1'b1;
            end
        end
    end

endmodule
